// File: rtl/csr_counter_unit.sv
// Machine/user counter CSRs (mcycle, minstret, time shadow, hpmcounters) with privilege checks.
// Reads are combinational from pre-edge state; writes and increments commit on the rising edge.
module csr_counter_unit #(
  parameter int NUM_HPM      = 4,
  parameter int CNT_WIDTH    = 64,
  parameter int RETIRE_WIDTH = 2
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_csr_rden,
  input  logic                                     i_csr_wren,
  input  logic [11:0]                              i_csr_addr,
  input  logic [31:0]                              i_csr_wdata,
  input  logic [1:0]                               i_priv_mode,
  input  logic [RETIRE_WIDTH-1:0]                  i_retire,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0]   i_hpm_event,
  input  logic [63:0]                              i_mtime,
  output logic [31:0]                              o_csr_rdata,
  output logic                                     o_csr_ill
);

  localparam int          NCNT      = 3 + NUM_HPM;
  localparam int          HW        = CNT_WIDTH - 32;
  localparam logic [63:0] EN_MASK64 = (64'd1 << NCNT) - 64'd1;
  localparam logic [31:0] EN_MASK   = EN_MASK64[31:0];
  localparam logic [31:0] INH_MASK  = EN_MASK & ~32'h2;

  // Indexed by CSR counter number; slot 1 (time) is never written and stays 0.
  logic [CNT_WIDTH-1:0] r_cnt [NCNT];
  logic [4:0]           r_evt [NCNT];
  logic [31:0]          r_inhibit;
  logic [31:0]          r_counteren;

  logic [CNT_WIDTH-1:0] w_cnt_nxt [NCNT];
  logic [6:0]           w_idx;
  logic                 w_priv_m;
  logic                 w_is_b;
  logic                 w_is_c;
  logic                 w_is_inh;
  logic                 w_is_en;
  logic                 w_is_evt;
  logic                 w_ill;
  logic                 w_wr;
  logic [31:0]          w_rval;

  assign w_idx    = i_csr_addr[6:0];
  assign w_priv_m = (i_priv_mode == 2'b11);
  assign w_is_b   = (i_csr_addr[11:8] == 4'hB) && (w_idx < 7'(NCNT)) && (w_idx != 7'd1);
  assign w_is_c   = (i_csr_addr[11:8] == 4'hC) && (w_idx < 7'(NCNT));
  assign w_is_inh = (i_csr_addr == 12'h320);
  assign w_is_en  = (i_csr_addr == 12'h306);
  assign w_is_evt = (i_csr_addr[11:5] == 7'h19) && (w_idx[4:0] >= 5'd3) &&
                    ({2'b00, w_idx[4:0]} < 7'(NCNT));

  always_comb begin
    w_ill = 1'b0;
    if (i_csr_rden || i_csr_wren) begin
      if (!(w_is_b || w_is_c || w_is_inh || w_is_en || w_is_evt))
        w_ill = 1'b1;
      else if (w_is_c)
        w_ill = i_csr_wren || (!w_priv_m && !r_counteren[w_idx[4:0]]);
      else
        w_ill = !w_priv_m;
    end
  end

  always_comb begin
    w_rval = 32'b0;
    if (w_is_b || w_is_c) begin
      if (w_idx == 7'd1)
        w_rval = i_csr_addr[7] ? i_mtime[63:32] : i_mtime[31:0];
      for (int i = 0; i < NCNT; i++) begin
        if (i != 1 && w_idx == 7'(i))
          w_rval = i_csr_addr[7] ? 32'(r_cnt[i][CNT_WIDTH-1:32]) : r_cnt[i][31:0];
      end
    end else if (w_is_inh) begin
      w_rval = r_inhibit;
    end else if (w_is_en) begin
      w_rval = r_counteren;
    end else if (w_is_evt) begin
      for (int i = 3; i < NCNT; i++) begin
        if (w_idx[4:0] == 5'(i))
          w_rval = {27'b0, r_evt[i]};
      end
    end
  end

  assign o_csr_ill   = i_rst_n && w_ill;
  assign o_csr_rdata = (i_rst_n && i_csr_rden && !w_ill) ? w_rval : 32'b0;
  assign w_wr        = i_csr_wren && !w_ill;

  // A written half replaces that half only; the counter skips its increment that cycle.
  always_comb begin
    for (int i = 0; i < NCNT; i++) begin
      logic [CNT_WIDTH-1:0] v_inc;
      logic                 v_hit;
      v_inc        = '0;
      v_hit        = 1'b0;
      w_cnt_nxt[i] = r_cnt[i];
      for (int e = 0; e < NUM_HPM; e++)
        v_hit = v_hit | ((r_evt[i] == 5'(e + 1)) && i_hpm_event[e]);
      if (i == 0)
        v_inc = CNT_WIDTH'(1);
      else if (i == 2)
        v_inc = CNT_WIDTH'(i_retire);
      else if (i >= 3)
        v_inc = CNT_WIDTH'(v_hit);
      if (i != 1) begin
        if (w_wr && w_is_b && w_idx == 7'(i)) begin
          if (i_csr_addr[7])
            w_cnt_nxt[i] = {i_csr_wdata[HW-1:0], r_cnt[i][31:0]};
          else
            w_cnt_nxt[i] = {r_cnt[i][CNT_WIDTH-1:32], i_csr_wdata};
        end else if (!r_inhibit[i]) begin
          w_cnt_nxt[i] = r_cnt[i] + v_inc;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCNT; i++) begin
        r_cnt[i] <= '0;
        r_evt[i] <= '0;
      end
      r_inhibit   <= '0;
      r_counteren <= '0;
    end else begin
      for (int i = 0; i < NCNT; i++)
        r_cnt[i] <= w_cnt_nxt[i];
      if (w_wr && w_is_inh)
        r_inhibit <= i_csr_wdata & INH_MASK;
      if (w_wr && w_is_en)
        r_counteren <= i_csr_wdata & EN_MASK;
      for (int i = 3; i < NCNT; i++) begin
        if (w_wr && w_is_evt && w_idx[4:0] == 5'(i))
          r_evt[i] <= i_csr_wdata[4:0];
      end
    end
  end

endmodule

// File: tb/tb_csr_counter_unit.sv
// Bench for csr_counter_unit: 64-bit and 40-bit instances share stimulus and are
// compared each cycle against a per-width reference model, plus directed expectations.
module tb_csr_counter_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rden = 1'b0;
  logic        wren = 1'b0;
  logic [11:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [1:0]  priv = 2'b11;
  logic [1:0]  retire = '0;
  logic [3:0]  hpm = '0;
  logic [63:0] mtime = '0;
  logic [31:0] rd64, rd40;
  logic        ill64, ill40;

  int total = 0;
  int bad = 0;

  bit [63:0] mc [2][7];
  bit [31:0] m_inh, m_en;
  bit [4:0]  m_evt [7];

  logic [11:0] alist [30] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
                              12'hB06, 12'hB83, 12'hB86, 12'hB01, 12'hB07, 12'hC00, 12'hC01,
                              12'hC02, 12'hC03, 12'hC06, 12'hC80, 12'hC81, 12'hC86, 12'hC07,
                              12'h320, 12'h306, 12'h323, 12'h324, 12'h326, 12'h327, 12'h321,
                              12'h000, 12'hB20};

  csr_counter_unit #(.NUM_HPM(4), .CNT_WIDTH(64), .RETIRE_WIDTH(2)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_csr_rden(rden), .i_csr_wren(wren),
    .i_csr_addr(addr), .i_csr_wdata(wdata), .i_priv_mode(priv), .i_retire(retire),
    .i_hpm_event(hpm), .i_mtime(mtime), .o_csr_rdata(rd64), .o_csr_ill(ill64));

  csr_counter_unit #(.NUM_HPM(4), .CNT_WIDTH(40), .RETIRE_WIDTH(2)) u_dut40 (
    .i_clk(clk), .i_rst_n(rst_n), .i_csr_rden(rden), .i_csr_wren(wren),
    .i_csr_addr(addr), .i_csr_wdata(wdata), .i_priv_mode(priv), .i_retire(retire),
    .i_hpm_event(hpm), .i_mtime(mtime), .o_csr_rdata(rd40), .o_csr_ill(ill40));

  initial forever #5 clk = ~clk;

  function automatic bit [63:0] wmask(input int wi);
    return (wi == 1) ? 64'h0000_00FF_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic void model_reset();
    for (int wi = 0; wi < 2; wi++)
      for (int i = 0; i < 7; i++) mc[wi][i] = 64'd0;
    for (int i = 0; i < 7; i++) m_evt[i] = 5'd0;
    m_inh = 32'd0;
    m_en  = 32'd0;
  endfunction

  // Expected response to the access currently on the inputs.
  function automatic void model_acc(input int wi, output bit ill, output bit [31:0] rd);
    int idx;
    bit [63:0] v;
    bit m;
    ill = 1'b0;
    rd  = 32'd0;
    v   = 64'd0;
    if (!rst_n || !(rden || wren)) return;
    idx = int'(addr[6:0]);
    m   = (priv == 2'b11);
    if (addr[11:8] == 4'hB && idx < 7 && idx != 1) begin
      ill = !m;
      v   = mc[wi][idx];
    end else if (addr[11:8] == 4'hC && idx < 7) begin
      ill = wren || (!m && !m_en[idx]);
      v   = (idx == 1) ? mtime : mc[wi][idx];
    end else if (addr == 12'h320) begin
      ill = !m;
      v   = {32'd0, m_inh};
    end else if (addr == 12'h306) begin
      ill = !m;
      v   = {32'd0, m_en};
    end else if (addr >= 12'h323 && addr <= 12'h326) begin
      ill = !m;
      v   = {59'd0, m_evt[int'(addr - 12'h320)]};
    end else begin
      ill = 1'b1;
    end
    if (rden && !ill) rd = addr[7] ? v[63:32] : v[31:0];
  endfunction

  task automatic model_edge();
    bit ill;
    bit [31:0] rd;
    bit wok;
    bit [63:0] inc;
    int e;
    model_acc(0, ill, rd);
    wok = wren && !ill;
    for (int wi = 0; wi < 2; wi++) begin
      for (int i = 0; i < 7; i++) begin
        if (i == 1) continue;
        e = int'(m_evt[i]);
        if (i == 0) inc = 64'd1;
        else if (i == 2) inc = 64'(retire);
        else inc = (e >= 1 && e <= 4 && hpm[e-1]) ? 64'd1 : 64'd0;
        if (wok && addr[11:8] == 4'hB && int'(addr[6:0]) == i)
          mc[wi][i] = addr[7] ? {wdata, mc[wi][i][31:0]} : {mc[wi][i][63:32], wdata};
        else if (!m_inh[i])
          mc[wi][i] = mc[wi][i] + inc;
        mc[wi][i] = mc[wi][i] & wmask(wi);
      end
    end
    if (wok && addr == 12'h320) m_inh = wdata & 32'h0000_007D;
    if (wok && addr == 12'h306) m_en  = wdata & 32'h0000_007F;
    if (wok && addr >= 12'h323 && addr <= 12'h326) m_evt[int'(addr - 12'h320)] = wdata[4:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set(input logic r, input logic w, input logic [11:0] a, input logic [31:0] d);
    rden  = r;
    wren  = w;
    addr  = a;
    wdata = d;
    #1;
  endtask

  task automatic step();
    bit ill_m;
    bit [31:0] rd_m;
    model_acc(0, ill_m, rd_m);
    chk("ill64", {31'd0, ill64}, {31'd0, ill_m});
    chk("rd64", rd64, rd_m);
    model_acc(1, ill_m, rd_m);
    chk("ill40", {31'd0, ill40}, {31'd0, ill_m});
    chk("rd40", rd40, rd_m);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    mtime = {$urandom, $urandom};
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    set(1'b0, 1'b1, a, d);
    step();
  endtask

  task automatic idle(input int n);
    set(1'b0, 1'b0, 12'h000, 32'd0);
    repeat (n) step();
  endtask

  initial begin
    logic [11:0] a;
    int k;
    model_reset();
    // Reset state
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    @(negedge clk);
    chk("rst_rd64", rd64, 32'd0);
    chk("rst_ill64", {31'd0, ill64}, 32'd0);
    chk("rst_rd40", rd40, 32'd0);
    rst_n = 1'b1;
    idle(10);
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    chk("mcycle_10_64", rd64, 32'd10);
    chk("mcycle_10_40", rd40, 32'd10);
    step();
    set(1'b1, 1'b0, 12'hB02, 32'd0);
    chk("minstret_0", rd64, 32'd0);
    step();

    // Carry across halves after write
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'h0);
    idle(2);
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    chk("carry_lo64", rd64, 32'd1);
    chk("carry_lo40", rd40, 32'd1);
    step();
    set(1'b1, 1'b0, 12'hB80, 32'd0);
    chk("carry_hi64", rd64, 32'd1);
    chk("carry_hi40", rd40, 32'd1);
    step();

    // Full-width wrap; upper bits of the 40-bit counter read 0
    wr(12'hB80, 32'hFFFF_FFFF);
    set(1'b1, 1'b0, 12'hB80, 32'd0);
    chk("hi_trunc40", rd40, 32'h0000_00FF);
    chk("hi_full64", rd64, 32'hFFFF_FFFF);
    step();
    wr(12'hB00, 32'hFFFF_FFFF);
    idle(1);
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    chk("wrap_lo64", rd64, 32'd0);
    chk("wrap_lo40", rd40, 32'd0);
    step();
    set(1'b1, 1'b0, 12'hB80, 32'd0);
    chk("wrap_hi64", rd64, 32'd0);
    chk("wrap_hi40", rd40, 32'd0);
    step();

    // Multi-retire and inhibit
    retire = 2'd2;
    idle(5);
    retire = 2'd0;
    set(1'b1, 1'b0, 12'hB02, 32'd0);
    chk("minstret_10", rd64, 32'd10);
    step();
    wr(12'h320, 32'd4);
    retire = 2'd2;
    idle(3);
    retire = 2'd0;
    set(1'b1, 1'b0, 12'hB02, 32'd0);
    chk("minstret_inh", rd64, 32'd10);
    step();
    wr(12'h320, 32'hFFFF_FFFF);
    set(1'b1, 1'b0, 12'h320, 32'd0);
    chk("inhibit_mask", rd64, 32'h0000_007D);
    step();
    wr(12'h320, 32'd0);

    // Event selection
    wr(12'h323, 32'd2);
    for (int i = 0; i < 7; i++) begin
      hpm = 4'b0010;
      idle(1);
      if (i < 4) begin
        hpm = 4'b0001;
        idle(1);
      end
    end
    hpm = 4'b0000;
    set(1'b1, 1'b0, 12'hB03, 32'd0);
    chk("hpm3_7", rd64, 32'd7);
    step();
    wr(12'h323, 32'd0);
    hpm = 4'b1111;
    idle(3);
    wr(12'h323, 32'd31);
    hpm = 4'b1111;
    idle(3);
    hpm = 4'b0000;
    set(1'b1, 1'b0, 12'hB03, 32'd0);
    chk("hpm3_hold", rd64, 32'd7);
    step();

    // Privilege checks
    priv = 2'b00;
    set(1'b1, 1'b0, 12'hC00, 32'd0);
    chk("u_c00_ill", {31'd0, ill64}, 32'd1);
    chk("u_c00_rd", rd64, 32'd0);
    step();
    priv = 2'b11;
    wr(12'h306, 32'd1);
    priv = 2'b00;
    set(1'b1, 1'b0, 12'hC00, 32'd0);
    chk("u_c00_ok", {31'd0, ill64}, 32'd0);
    chk("u_c00_val", rd64, mc[0][0][31:0]);
    step();
    set(1'b1, 1'b0, 12'hC01, 32'd0);
    chk("u_c01_ill", {31'd0, ill40}, 32'd1);
    step();
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    chk("u_b00_ill", {31'd0, ill64}, 32'd1);
    step();
    set(1'b0, 1'b1, 12'hC02, 32'd5);
    chk("u_wr_c02", {31'd0, ill64}, 32'd1);
    step();
    priv = 2'b11;
    set(1'b0, 1'b1, 12'hC02, 32'd5);
    chk("m_wr_c02", {31'd0, ill64}, 32'd1);
    step();
    set(1'b1, 1'b0, 12'hB02, 32'd0);
    chk("minstret_kept", rd64, 32'd10);
    step();
    set(1'b1, 1'b0, 12'hC81, 32'd0);
    chk("mtime_hi", rd64, mtime[63:32]);
    step();

    // csrrw returns the old value
    set(1'b1, 1'b1, 12'hB02, 32'h55);
    chk("csrrw_old", rd64, 32'd10);
    step();
    set(1'b1, 1'b0, 12'hB02, 32'd0);
    chk("csrrw_new", rd64, 32'h55);
    step();

    // Asynchronous reset mid-cycle
    priv = 2'b00;
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_rd", rd64, 32'd0);
    chk("arst_ill", {31'd0, ill64}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    priv = 2'b11;
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    chk("post_rst_0", rd64, 32'd0);
    step();
    set(1'b1, 1'b0, 12'hB00, 32'd0);
    chk("post_rst_1", rd64, 32'd1);
    step();

    // Randomised traffic against the model
    repeat (400) begin
      priv   = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
      retire = 2'($urandom);
      hpm    = 4'($urandom);
      a      = alist[$urandom_range(0, 29)];
      k      = $urandom_range(0, 9);
      set(k >= 3 && k <= 8, k <= 2 || k == 8, a,
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 3) : $urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
